jk_commander: RTL and testbench
===============================

# jk_commander

Initiator-side driver for a two-state J/K Moore responder, where j sets the responder on, k sets it off, and its single output reflects the state. The block accepts one on/off command per valid/ready handshake and drives a one-cycle j or k pulse. It then watches the responder's state output until it matches the target, retrying on timeout. It reports completion or failure with a one-cycle response pulse, and sits between control logic and any fsm2-style state element in the design.

## Interface
Parameters:
- TIMEOUT, default 8: cycles spent in WAIT per attempt before declaring a miss. Must be ≥1.
- MAX_RETRY, default 2: extra drive attempts after the first. Must be ≥0.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- reset, input, 1: synchronous, active-high. Sampled on posedge clk.
- cmd_valid, input, 1: command request.
- cmd_on, input, 1: target level (1 = on via j, 0 = off via k). Sampled with cmd_valid.
- cmd_ready, output, 1: high only in IDLE.
- j, output, 1: set pulse to the responder.
- k, output, 1: clear pulse to the responder.
- fb_out, input, 1: responder state output.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle response strobe.
- err, output, 1: valid with done. 1 = target not reached after all attempts.

## Operation
- States:
  - **IDLE:** cmd_ready=1. On cmd_valid, latch target=cmd_on and clear the retry count and fail flag. If fb_out==target in the same cycle, go to RESP with no drive; otherwise go to DRIVE. If cmd_valid is low, stay.
  - **DRIVE:** exactly one cycle. j=target, k=~target. Clear the timer. Next state is WAIT.
  - **WAIT:** j=k=0. The timer increments each cycle.
    - If fb_out==target, go to RESP with fail=0. A match wins over timeout in the same cycle.
    - Else if timer==TIMEOUT-1 and retry<MAX_RETRY, increment retry and go to DRIVE.
    - Else if timer==TIMEOUT-1, go to RESP with fail=1.
  - **RESP:** done=1, err=fail. Next state is IDLE.
- Outputs are a Moore decode of the registered state and target. j and k are never high together, and both are 0 outside DRIVE.
- cmd_valid outside IDLE is ignored: no queueing, no latching.
- fb_out changes outside WAIT and the IDLE accept cycle are ignored.
- Timer width is $clog2(TIMEOUT+1) and it saturates at no point beyond TIMEOUT-1. Retry width is $clog2(MAX_RETRY+1)+1. Counters never wrap.
- Reset, including reset mid-command in any state:
  - The next state is IDLE.
  - j=k=done=err=busy=0 and cmd_ready=1.
  - Timer, retry, fail and target are all 0.
  - The aborted command produces no done.

## Timing
- Accept in cycle 0 (IDLE with cmd_valid high). DRIVE occupies cycle 1.
- A responder that updates on the posedge ending cycle 1 shows its match in cycle 2 (first WAIT). done and err assert in cycle 3. Minimum driven latency is 3 cycles.
- Already-at-target: done is asserted in cycle 1 and j/k are never pulsed.
- Worst case: done is asserted 1 + (MAX_RETRY+1)·(1+TIMEOUT) cycles after accept.
- The next command can be accepted in the cycle after RESP, giving back-to-back throughput of one command per (latency+1) cycles.

## Structure
- Package jk_cmd_pkg holds:
  - the state enum: IDLE, DRIVE, WAIT, RESP, 2-bit, binary-encoded;
  - localparam helpers for the timer and retry widths.
- One sub-module, jk_timeout_ctr: a clearable up-counter with a terminal-count flag at TIMEOUT-1, clear driven in DRIVE. The FSM, target register and retry counter stay in jk_commander.

## Test plan
All scenarios use TIMEOUT=4, MAX_RETRY=2 and a behavioural fsm2-style responder unless stated.
1. After reset, cmd_on=1 with fb_out=0 and a responsive model: j=1 in cycle 1 only, k=0 throughout, done=1 and err=0 in cycle 3, cmd_ready=1 in cycle 4.
2. fb_out=1 and cmd_on=1 at accept: no j/k pulse, done=1 and err=0 in cycle 1.
3. Responder stuck at 0, cmd_on=1: j pulses in cycles 1, 6 and 11. done=1 and err=1 in cycle 16. busy is high in cycles 1–16.
4. Responder delayed 3 cycles, with fb_out rising in the third WAIT cycle (cycle 4): a single j pulse, no retry, done=1 and err=0 in cycle 5.
5. cmd_on=0 from on, with reset asserted in cycle 3 (WAIT):
   - From cycle 4: IDLE, cmd_ready=1, j=k=done=err=0, and no done ever appears for the aborted command.
   - A cmd_valid pulse in cycle 2 (busy) is not accepted.
6. Back-to-back on then off commands with cmd_valid held high: k pulses exactly one cycle after the second accept, and the two done strobes are separated by 4 cycles.

Source files
------------

// File: rtl/jk_cmd_pkg.sv
// Shared types and width helpers for the J/K commander.
package jk_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } jk_state_e;

  localparam int unsigned DefTimeout  = 8;
  localparam int unsigned DefMaxRetry = 2;

  function automatic int unsigned timer_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

  function automatic int unsigned retry_w(input int unsigned max_retry);
    return $clog2(max_retry + 1) + 1;
  endfunction

endpackage

// File: rtl/jk_timeout_ctr.sv
// Clearable per-attempt wait timer; tc flags the last cycle of an attempt.
module jk_timeout_ctr
  import jk_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned TW = timer_w(TIMEOUT);
  localparam logic [TW-1:0] Last = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;

  // Holds at Last rather than wrapping; the FSM leaves WAIT on that cycle anyway.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (en && (count_q != Last)) begin
      count_q <= count_q + TW'(1);
    end
  end

  assign tc = (count_q == Last);

endmodule

// File: rtl/jk_commander.sv
// Drives a J/K responder to a commanded level, retrying on timeout, and
// reports completion with a one-cycle done/err strobe.
module jk_commander
  import jk_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT   = DefTimeout,
  parameter int unsigned MAX_RETRY = DefMaxRetry
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  input  logic cmd_on,
  output logic cmd_ready,
  output logic j,
  output logic k,
  input  logic fb_out,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned RW = retry_w(MAX_RETRY);
  localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);

  jk_state_e     state_q, state_d;
  logic          target_q, target_d;
  logic          fail_q, fail_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          tc;

  jk_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == DRIVE),
    .en   (state_q == WAIT),
    .tc   (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      fail_q   <= 1'b0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      fail_q   <= fail_d;
      retry_q  <= retry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    fail_d   = fail_q;
    retry_d  = retry_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_on;
          retry_d  = '0;
          fail_d   = 1'b0;
          // Already at target: skip the drive and respond immediately.
          state_d  = (fb_out == cmd_on) ? RESP : DRIVE;
        end
      end
      DRIVE: state_d = WAIT;
      WAIT: begin
        if (fb_out == target_q) begin
          fail_d  = 1'b0;
          state_d = RESP;
        end else if (tc) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + RW'(1);
            state_d = DRIVE;
          end else begin
            fail_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    j         = (state_q == DRIVE) && target_q;
    k         = (state_q == DRIVE) && !target_q;
    done      = (state_q == RESP);
    err       = (state_q == RESP) && fail_q;
  end

endmodule

// File: tb/tb_jk_commander.sv
// Directed bench for jk_commander with TIMEOUT=4, MAX_RETRY=2 and a
// behavioural J/K responder that can be overridden with a forced level.
module tb_jk_commander;

  logic clk = 1'b0;
  logic reset, cmd_valid, cmd_on, fb_out;
  logic cmd_ready, j, k, busy, done, err;

  logic use_model, fb_force, model_q;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  jk_commander #(
    .TIMEOUT  (4),
    .MAX_RETRY(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_on   (cmd_on),
    .cmd_ready(cmd_ready),
    .j        (j),
    .k        (k),
    .fb_out   (fb_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // fsm2-style responder: j sets, k clears, output is the state.
  always @(posedge clk) begin
    if (reset) model_q <= 1'b0;
    else if (j) model_q <= 1'b1;
    else if (k) model_q <= 1'b0;
  end

  assign fb_out = use_model ? model_q : fb_force;

  // Expected vector order: {cmd_ready, busy, j, k, done, err}
  localparam logic [5:0] EIdle   = 6'b100000;
  localparam logic [5:0] EDriveJ = 6'b011000;
  localparam logic [5:0] EDriveK = 6'b010100;
  localparam logic [5:0] EWait   = 6'b010000;
  localparam logic [5:0] ERespOk = 6'b010010;
  localparam logic [5:0] ERespEr = 6'b010011;

  task automatic check(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {cmd_ready, busy, j, k, done, err};
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check this cycle's outputs, then move to the next cycle.
  task automatic step(input string tag, input logic [5:0] exp);
    check(tag, exp);
    tick();
  endtask

  initial begin
    logic [5:0] exp;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_on    = 1'b0;
    use_model = 1'b1;
    fb_force  = 1'b0;
    tick();
    check("reset_state", EIdle);
    tick();
    reset = 1'b0;

    // 1: on command, responsive model
    cmd_valid = 1'b1; cmd_on = 1'b1;
    step("t1_c0_idle", EIdle);
    cmd_valid = 1'b0;
    step("t1_c1_drive_j", EDriveJ);
    step("t1_c2_wait", EWait);
    step("t1_c3_done", ERespOk);
    step("t1_c4_ready", EIdle);

    // 2: already on, no drive
    cmd_valid = 1'b1; cmd_on = 1'b1;
    step("t2_c0_idle", EIdle);
    cmd_valid = 1'b0;
    step("t2_c1_done", ERespOk);
    step("t2_c2_ready", EIdle);

    // 3: responder stuck at 0, all retries exhausted
    use_model = 1'b0; fb_force = 1'b0;
    cmd_valid = 1'b1; cmd_on = 1'b1;
    step("t3_c0_idle", EIdle);
    cmd_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 16) exp = ERespEr;
      else if (c == 1 || c == 6 || c == 11) exp = EDriveJ;
      else exp = EWait;
      step($sformatf("t3_c%0d", c), exp);
    end
    step("t3_c17_ready", EIdle);

    // 4: responder matches in the third WAIT cycle
    fb_force  = 1'b0;
    cmd_valid = 1'b1; cmd_on = 1'b1;
    step("t4_c0_idle", EIdle);
    cmd_valid = 1'b0;
    step("t4_c1_drive_j", EDriveJ);
    step("t4_c2_wait", EWait);
    step("t4_c3_wait", EWait);
    fb_force = 1'b1;
    step("t4_c4_wait", EWait);
    step("t4_c5_done", ERespOk);
    step("t4_c6_ready", EIdle);

    // 5: off command from on, ignored cmd_valid while busy, reset in WAIT
    fb_force  = 1'b1;
    cmd_valid = 1'b1; cmd_on = 1'b0;
    step("t5_c0_idle", EIdle);
    cmd_valid = 1'b0;
    step("t5_c1_drive_k", EDriveK);
    cmd_valid = 1'b1; cmd_on = 1'b1;
    step("t5_c2_wait", EWait);
    cmd_valid = 1'b0; reset = 1'b1;
    step("t5_c3_wait", EWait);
    reset = 1'b0;
    for (int c = 4; c <= 10; c++) step($sformatf("t5_c%0d_idle", c), EIdle);

    // 6: back-to-back on then off with cmd_valid held high
    use_model = 1'b1;
    cmd_valid = 1'b1; cmd_on = 1'b1;
    step("t6_c0_idle", EIdle);
    step("t6_c1_drive_j", EDriveJ);
    step("t6_c2_wait", EWait);
    step("t6_c3_done", ERespOk);
    cmd_on = 1'b0;
    step("t6_c4_accept", EIdle);
    cmd_valid = 1'b0;
    step("t6_c5_drive_k", EDriveK);
    step("t6_c6_wait", EWait);
    step("t6_c7_done", ERespOk);
    step("t6_c8_ready", EIdle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
